sram_ctrl_param: RTL and testbench
==================================

SRAM_CTRL_PARAM -- requirements
Module: sram_ctrl_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the CPU-side word width: a multiple of 16, from 16 to 64.
REQ-002 The block SHALL have parameter ADDR_W, default 18, meaning the SRAM halfword address width.
REQ-003 The block SHALL have parameter WAIT_STATES, default 4, meaning the number of cycles each SRAM halfword access is held; minimum 1.
REQ-004 The block SHALL have parameter BASE_ADDR, default 1024, meaning the CPU byte address that maps to SRAM halfword 0.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port rdEn, input, 1 bit: read request, held by the requester until ready=1.
REQ-008 The block SHALL have port wrEn, input, 1 bit: write request, held by the requester until ready=1.
REQ-009 The block SHALL have port address, input, 32 bits: CPU byte address.
REQ-010 The block SHALL have port writeData, input, DATA_W bits: store data.
REQ-011 The block SHALL have port readData, output, DATA_W bits: load result, registered.
REQ-012 The block SHALL have port ready, output, 1 bit: access complete or no access pending; the pipeline freeze = (rdEn|wrEn) & ~ready.
REQ-013 The block SHALL have port SRAM_DQ, inout, 16 bits: SRAM data bus.
REQ-014 The block SHALL have port SRAM_ADDR, output, ADDR_W bits: SRAM halfword address.
REQ-015 The block SHALL have ports SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N and SRAM_OE_N, each output, 1 bit: active-low SRAM controls.

Function
REQ-016 N SHALL equal DATA_W/16, the number of halfwords per access.
REQ-017 Word index SHALL equal (address - BASE_ADDR) >> log2(DATA_W/8), with subtraction modulo 2^32.
REQ-018 Halfword k (k = 0..N-1) SHALL be at SRAM_ADDR = (wordIndex*N + k) truncated to ADDR_W bits, i.e. wrap-around modulo 2^ADDR_W; low byte offset bits SHALL be ignored.
REQ-019 The FSM SHALL have states IDLE, ACCESS, DONE.
REQ-020 In IDLE with rdEn|wrEn, the block SHALL latch the address, writeData and operation and go to ACCESS; if both rdEn and wrEn are high, the write SHALL win.
REQ-021 In ACCESS, a wait counter SHALL count 0..WAIT_STATES-1 per halfword and a halfword counter SHALL count 0..N-1; after the last cycle of halfword N-1 the FSM SHALL go to DONE.
REQ-022 DONE SHALL last exactly one cycle, then go to IDLE unconditionally; a request still high in DONE is the completed one and SHALL NOT restart.
REQ-023 ready SHALL be combinational: 1 in DONE, 1 in IDLE when rdEn=wrEn=0, 0 otherwise.
REQ-024 Latency SHALL be: ready low for N*WAIT_STATES+1 cycles from the first request cycle (9 for DATA_W=32, WAIT_STATES=4), then high for 1 cycle.
REQ-025 During a write in ACCESS, SRAM_WE_N SHALL be 0 and SRAM_DQ SHALL be driven with halfword k of the latched data (k=0 is the least significant).
REQ-026 Outside a write in ACCESS, SRAM_DQ SHALL be high-Z and SRAM_WE_N SHALL be 1.
REQ-027 During a read, SRAM_DQ SHALL be sampled on the last wait cycle of halfword k into readData[16k+15:16k]; readData SHALL hold its value until the next read overwrites it.
REQ-028 SRAM_CE_N, SRAM_OE_N, SRAM_UB_N and SRAM_LB_N SHALL be held at 0 at all times.
REQ-029 SRAM_ADDR SHALL be 0 in IDLE and DONE.
REQ-030 Deasserting the request mid-ACCESS SHALL NOT abort the access; it SHALL complete and pass through DONE.
REQ-031 Back-to-back requests SHALL have at least 1 IDLE cycle between DONE and the next ACCESS.

Reset
REQ-032 On rst=1, the FSM SHALL go to IDLE and both counters SHALL clear immediately, without waiting for a clock edge.
REQ-033 On rst=1, readData SHALL be 0, SRAM_WE_N SHALL be 1, SRAM_DQ SHALL be high-Z and SRAM_ADDR SHALL be 0.
REQ-034 Reset asserted mid-write SHALL release SRAM_WE_N and SRAM_DQ within the same cycle.
REQ-035 After reset deassertion, a held request SHALL start a new full access.

Verification
REQ-036 Bench SHALL cover: DATA_W=32, WAIT_STATES=4, write 0xDEADBEEF at address 1024 -> SRAM halfword 0 = 0xBEEF, halfword 1 = 0xDEAD, WE_N low 8 cycles, ready high on cycle 10.
REQ-037 Bench SHALL cover: read of the same address -> readData = 0xDEADBEEF with ready pulse after 9 low cycles; SRAM_DQ never driven by the block.
REQ-038 Bench SHALL cover: DATA_W=64, WAIT_STATES=1, write 0x0123456789ABCDEF at address 1032 -> halfwords 4..7 = 0xCDEF, 0x89AB, 0x4567, 0x0123; ready low 5 cycles.
REQ-039 Bench SHALL cover: rdEn=wrEn=1 simultaneously -> write performed; readData unchanged.
REQ-040 Bench SHALL cover: address 1020 with ADDR_W=18, DATA_W=32 -> SRAM_ADDR = 0x3FFFE, then 0x3FFFF (wrap).
REQ-041 Bench SHALL cover: rst pulse during halfword 1 of a write -> SRAM_WE_N=1 and DQ high-Z in the same cycle; after release, the held request completes in a full 9+1 cycles.

Source files
------------

// File: rtl/sram_ctrl_param.sv
// sram_ctrl_param: bridges DATA_W-bit CPU loads/stores onto a 16-bit async SRAM.
// Each access is split into DATA_W/16 halfwords, each held for WAIT_STATES clocks.
module sram_ctrl_param #(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 18,
    parameter int          WAIT_STATES = 4,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdEn,
    input  logic              wrEn,
    input  logic [31:0]       address,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData,
    output logic              ready,
    inout  wire  [15:0]       SRAM_DQ,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N
);

    localparam int N     = DATA_W / 16;
    localparam int SHIFT = $clog2(DATA_W / 8);
    localparam int WCW   = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam int HCW   = (N > 1) ? $clog2(N) : 1;

    localparam logic [WCW-1:0] LAST_WAIT = WCW'(WAIT_STATES - 1);
    localparam logic [HCW-1:0] LAST_HW   = HCW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } stateT;

    stateT state;
    stateT nextState;

    logic [WCW-1:0]    waitCnt;
    logic [HCW-1:0]    hwCnt;
    logic              opWrite;
    logic [DATA_W-1:0] dataReg;
    logic [ADDR_W-1:0] baseHw;
    logic [ADDR_W-1:0] reqHw;
    logic [31:0]       wordIndex;
    logic              reqAny;
    logic              lastWait;
    logic              lastHw;
    logic              dqDrive;
    logic [15:0]       dqOut;

    assign reqAny   = rdEn | wrEn;
    assign lastWait = (waitCnt == LAST_WAIT);
    assign lastHw   = (hwCnt == LAST_HW);

    // Offset wraps modulo 2^32; the final cast wraps modulo 2^ADDR_W.
    assign wordIndex = (address - BASE_ADDR) >> SHIFT;
    assign reqHw     = ADDR_W'(wordIndex * 32'(N));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        ready     = 1'b0;
        dqDrive   = 1'b0;
        SRAM_WE_N = 1'b1;
        SRAM_ADDR = '0;
        unique case (state)
            IDLE: begin
                ready = ~reqAny;
                if (reqAny) begin
                    nextState = ACCESS;
                end
            end
            ACCESS: begin
                SRAM_ADDR = baseHw + ADDR_W'(hwCnt);
                SRAM_WE_N = ~opWrite;
                dqDrive   = opWrite;
                if (lastWait && lastHw) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                ready     = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waitCnt <= '0;
            hwCnt   <= '0;
        end else if (state == ACCESS) begin
            if (lastWait) begin
                waitCnt <= '0;
                hwCnt   <= lastHw ? '0 : hwCnt + 1'b1;
            end else begin
                waitCnt <= waitCnt + 1'b1;
            end
        end else begin
            waitCnt <= '0;
            hwCnt   <= '0;
        end
    end

    // Request is captured once; later changes on the CPU side are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opWrite <= 1'b0;
            dataReg <= '0;
            baseHw  <= '0;
        end else if (state == IDLE && reqAny) begin
            opWrite <= wrEn;
            dataReg <= writeData;
            baseHw  <= reqHw;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            readData <= '0;
        end else if (state == ACCESS && !opWrite && lastWait) begin
            for (int k = 0; k < N; k++) begin
                if (hwCnt == HCW'(k)) begin
                    readData[16*k +: 16] <= SRAM_DQ;
                end
            end
        end
    end

    always_comb begin
        dqOut = '0;
        for (int k = 0; k < N; k++) begin
            if (hwCnt == HCW'(k)) begin
                dqOut = dataReg[16*k +: 16];
            end
        end
    end

    assign SRAM_DQ = dqDrive ? dqOut : 16'hzzzz;

    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_ctrl_param.sv
// tb_sram_ctrl_param: directed vectors against a 32-bit/4-wait and a 64-bit/1-wait
// controller, each attached to a simple behavioural SRAM.
module tb_sram_ctrl_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        rd0 = 1'b0, wr0 = 1'b0;
    logic [31:0] addr0 = '0;
    logic [31:0] wd0 = '0;
    logic [31:0] rdData0;
    logic        ready0;
    wire  [15:0] dq0;
    logic [17:0] sAddr0;
    logic        ub0, lb0, we0, ce0, oe0;

    logic        rd1 = 1'b0, wr1 = 1'b0;
    logic [31:0] addr1 = '0;
    logic [63:0] wd1 = '0;
    logic [63:0] rdData1;
    logic        ready1;
    wire  [15:0] dq1;
    logic [17:0] sAddr1;
    logic        ub1, lb1, we1, ce1, oe1;

    sram_ctrl_param u32 (
        .clk(clk), .rst(rst), .rdEn(rd0), .wrEn(wr0),
        .address(addr0), .writeData(wd0), .readData(rdData0),
        .ready(ready0), .SRAM_DQ(dq0), .SRAM_ADDR(sAddr0),
        .SRAM_UB_N(ub0), .SRAM_LB_N(lb0), .SRAM_WE_N(we0),
        .SRAM_CE_N(ce0), .SRAM_OE_N(oe0)
    );

    sram_ctrl_param #(.DATA_W(64), .WAIT_STATES(1)) u64 (
        .clk(clk), .rst(rst), .rdEn(rd1), .wrEn(wr1),
        .address(addr1), .writeData(wd1), .readData(rdData1),
        .ready(ready1), .SRAM_DQ(dq1), .SRAM_ADDR(sAddr1),
        .SRAM_UB_N(ub1), .SRAM_LB_N(lb1), .SRAM_WE_N(we1),
        .SRAM_CE_N(ce1), .SRAM_OE_N(oe1)
    );

    logic [15:0] mem0 [0:(1<<18)-1];
    logic [15:0] mem1 [0:(1<<18)-1];

    assign dq0 = we0 ? mem0[sAddr0] : 16'hzzzz;
    assign dq1 = we1 ? mem1[sAddr1] : 16'hzzzz;

    always @(posedge clk) begin
        if (!we0) mem0[sAddr0] <= dq0;
        if (!we1) mem1[sAddr1] <= dq1;
    end

    int nCmp = 0;
    int nBad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic dropReq(input bit wide);
        if (wide) begin
            rd1 = 1'b0;
            wr1 = 1'b0;
        end else begin
            rd0 = 1'b0;
            wr0 = 1'b0;
        end
    endtask

    // Called on the negedge where the request was raised; returns inside DONE.
    task automatic measure(input bit wide, input int dropAt,
                           output int low, output int weLow,
                           output logic [17:0] aFirst, output logic [17:0] aLast,
                           output logic [17:0] aDone, output bit ok);
        low = 0; weLow = 0; ok = 1'b0;
        aFirst = '0; aLast = '0; aDone = '0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (wide ? ready1 : ready0) begin
                ok = 1'b1;
                aDone = wide ? sAddr1 : sAddr0;
                break;
            end
            if (!(wide ? we1 : we0)) weLow++;
            if (c == 1) aFirst = wide ? sAddr1 : sAddr0;
            if (c >= 1) aLast = wide ? sAddr1 : sAddr0;
            low++;
            if (dropAt != 0 && low == dropAt) dropReq(wide);
            @(negedge clk);
        end
        dropReq(wide);
    endtask

    typedef struct {
        bit        wide;
        bit        rd;
        bit        wr;
        bit [31:0] addr;
        bit [63:0] wdata;
        bit [63:0] expRead;
        int        expLow;
        int        expWe;
        bit [17:0] expFirst;
        bit [17:0] expLast;
        int        dropAt;
    } vecT;

    localparam int NV = 14;
    vecT vecs [NV];

    int          low, weLow;
    logic [17:0] aFirst, aLast, aDone;
    bit          ok;
    logic [63:0] rdNow;

    initial begin
        vecs[0]  = '{0, 0, 1, 32'd1024, 64'hDEADBEEF, 64'h0, 9, 8, 18'h0, 18'h1, 0};
        vecs[1]  = '{0, 1, 0, 32'd1024, 64'h0, 64'hDEADBEEF, 9, 0, 18'h0, 18'h1, 0};
        vecs[2]  = '{0, 0, 1, 32'd1028, 64'h11223344, 64'hDEADBEEF, 9, 8, 18'h2, 18'h3, 0};
        vecs[3]  = '{0, 1, 0, 32'd1028, 64'h0, 64'h11223344, 9, 0, 18'h2, 18'h3, 0};
        vecs[4]  = '{0, 1, 1, 32'd1036, 64'hCAFEF00D, 64'h11223344, 9, 8, 18'h6, 18'h7, 0};
        vecs[5]  = '{0, 1, 0, 32'd1036, 64'h0, 64'hCAFEF00D, 9, 0, 18'h6, 18'h7, 0};
        vecs[6]  = '{0, 0, 1, 32'd1020, 64'hA5A55A5A, 64'hCAFEF00D, 9, 8, 18'h3FFFE, 18'h3FFFF, 0};
        vecs[7]  = '{0, 1, 0, 32'd1020, 64'h0, 64'hA5A55A5A, 9, 0, 18'h3FFFE, 18'h3FFFF, 0};
        vecs[8]  = '{0, 1, 0, 32'd1027, 64'h0, 64'hDEADBEEF, 9, 0, 18'h0, 18'h1, 0};
        vecs[9]  = '{0, 1, 0, 32'd1028, 64'h0, 64'h11223344, 9, 0, 18'h2, 18'h3, 3};
        vecs[10] = '{1, 0, 1, 32'd1032, 64'h0123456789ABCDEF, 64'h0, 5, 4, 18'h4, 18'h7, 0};
        vecs[11] = '{1, 1, 0, 32'd1032, 64'h0, 64'h0123456789ABCDEF, 5, 0, 18'h4, 18'h7, 0};
        vecs[12] = '{1, 0, 1, 32'd1024, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 5, 4, 18'h0, 18'h3, 0};
        vecs[13] = '{1, 1, 0, 32'd1024, 64'h0, 64'hFEDCBA9876543210, 5, 0, 18'h0, 18'h3, 0};

        @(negedge clk);
        #1;
        chk("reset ready32", 64'(ready0), 64'h1);
        chk("reset ready64", 64'(ready1), 64'h1);
        chk("reset we32", 64'(we0), 64'h1);
        chk("reset addr32", 64'(sAddr0), 64'h0);
        chk("reset rdData32", 64'(rdData0), 64'h0);
        chk("reset rdData64", rdData1, 64'h0);
        chk("static ctl32", 64'({ub0, lb0, ce0, oe0}), 64'h0);
        chk("static ctl64", 64'({ub1, lb1, ce1, oe1}), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            if (vecs[i].wide) begin
                rd1 = vecs[i].rd; wr1 = vecs[i].wr;
                addr1 = vecs[i].addr; wd1 = vecs[i].wdata;
            end else begin
                rd0 = vecs[i].rd; wr0 = vecs[i].wr;
                addr0 = vecs[i].addr; wd0 = vecs[i].wdata[31:0];
            end
            measure(vecs[i].wide, vecs[i].dropAt, low, weLow, aFirst, aLast, aDone, ok);
            rdNow = vecs[i].wide ? rdData1 : {32'h0, rdData0};
            chk($sformatf("v%0d ready seen", i), 64'(ok), 64'h1);
            chk($sformatf("v%0d low cycles", i), 64'(low), 64'(vecs[i].expLow));
            chk($sformatf("v%0d WE_N low cycles", i), 64'(weLow), 64'(vecs[i].expWe));
            chk($sformatf("v%0d first addr", i), 64'(aFirst), 64'(vecs[i].expFirst));
            chk($sformatf("v%0d last addr", i), 64'(aLast), 64'(vecs[i].expLast));
            chk($sformatf("v%0d DONE addr", i), 64'(aDone), 64'h0);
            chk($sformatf("v%0d readData", i), rdNow, vecs[i].expRead);
            @(negedge clk);
            #1;
            chk($sformatf("v%0d idle ready", i), 64'(vecs[i].wide ? ready1 : ready0), 64'h1);
        end

        chk("mem32 hw0", 64'(mem0[0]), 64'hBEEF);
        chk("mem32 hw1", 64'(mem0[1]), 64'hDEAD);
        chk("mem32 hw6", 64'(mem0[6]), 64'hF00D);
        chk("mem32 hw7", 64'(mem0[7]), 64'hCAFE);
        chk("mem32 wrap lo", 64'(mem0[18'h3FFFE]), 64'h5A5A);
        chk("mem32 wrap hi", 64'(mem0[18'h3FFFF]), 64'hA5A5);
        chk("mem64 hw4", 64'(mem1[4]), 64'hCDEF);
        chk("mem64 hw5", 64'(mem1[5]), 64'h89AB);
        chk("mem64 hw6", 64'(mem1[6]), 64'h4567);
        chk("mem64 hw7", 64'(mem1[7]), 64'h0123);

        // Reset in the middle of halfword 1 of a write, request held throughout.
        @(negedge clk);
        wr0 = 1'b1; rd0 = 1'b0; addr0 = 32'd1040; wd0 = 32'h55667788;
        repeat (6) @(negedge clk);
        #1;
        chk("rstseq WE_N before", 64'(we0), 64'h0);
        chk("rstseq addr before", 64'(sAddr0), 64'h9);
        rst = 1'b1;
        #1;
        chk("rstseq WE_N released", 64'(we0), 64'h1);
        chk("rstseq addr cleared", 64'(sAddr0), 64'h0);
        chk("rstseq DQ not driven", 64'(dq0), 64'(mem0[0]));
        chk("rstseq ready", 64'(ready0), 64'h0);
        chk("rstseq rdData32", 64'(rdData0), 64'h0);
        chk("rstseq rdData64", rdData1, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        measure(1'b0, 0, low, weLow, aFirst, aLast, aDone, ok);
        chk("rstseq ready seen", 64'(ok), 64'h1);
        chk("rstseq low cycles", 64'(low), 64'd9);
        chk("rstseq WE_N low cycles", 64'(weLow), 64'd8);
        chk("rstseq first addr", 64'(aFirst), 64'h8);
        @(negedge clk);
        #1;
        chk("rstseq idle ready", 64'(ready0), 64'h1);
        chk("rstseq mem hw8", 64'(mem0[8]), 64'h7788);
        chk("rstseq mem hw9", 64'(mem0[9]), 64'h5566);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
